// File: rtl/chop_demod_pkg.sv
// Shared defaults and helpers for the receive-side chop demodulator.
// Default widths and the chop polarity must agree with the chopper generator.
package chop_demod_pkg;

  localparam int   ADC_DW_DEF       = 18;
  localparam int   N_CHAN_DEF       = 32;
  localparam logic CHOP_DEFAULT_DEF = 1'b0;
  localparam int   MAX_HOLD_DEF     = 8;
  localparam int   CHAN_W           = 6;
  localparam int   HOLD_CNT_W       = 4;

  // Saturating increment so a very long hold window cannot wrap back below the trip level
  function automatic logic [HOLD_CNT_W-1:0] hold_cnt_inc(input logic [HOLD_CNT_W-1:0] cnt);
    if (cnt == {HOLD_CNT_W{1'b1}}) begin
      hold_cnt_inc = cnt;
    end else begin
      hold_cnt_inc = cnt + HOLD_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/sat_negate.sv
// Conditional two's-complement negate that clamps the most negative code to the
// most positive one instead of wrapping.
module sat_negate #(
  parameter int W = 18
) (
  input  logic                neg,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] dout
);

  localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};

  // Select pass-through, exact negation, or the saturated positive limit
  always_comb begin
    dout = din;
    if (neg) begin
      if (din == MIN_V) begin
        dout = MAX_V;
      end else begin
        dout = -din;
      end
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/chop_demod.sv
// Receive-side dechopper: undoes the +/-1 chop modulation per sample and substitutes each
// channel's last good value during generator hold windows. Two register stages, no backpressure.
module chop_demod
  import chop_demod_pkg::*;
#(
  parameter int   ADC_DW       = ADC_DW_DEF,
  parameter int   N_CHAN       = N_CHAN_DEF,
  parameter logic CHOP_DEFAULT = CHOP_DEFAULT_DEF,
  parameter int   MAX_HOLD     = MAX_HOLD_DEF
) (
  input  logic              adc_data_clk,
  input  logic              reset_n,
  input  logic              chop_en,
  input  logic              chop_dly_i,
  input  logic              data_hold_i,
  input  logic              s_valid,
  input  logic [CHAN_W-1:0] s_chan,
  input  logic [ADC_DW-1:0] s_data,
  output logic              m_valid,
  output logic [CHAN_W-1:0] m_chan,
  output logic [ADC_DW-1:0] m_data,
  output logic              m_held,
  output logic              period_stb_o,
  output logic              err_chan_o,
  output logic              err_hold_o
);

  localparam int                    IDX_W     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam logic [CHAN_W:0]       N_CHAN_L  = (CHAN_W + 1)'(N_CHAN);
  localparam logic [HOLD_CNT_W-1:0] HOLD_TRIP = HOLD_CNT_W'(MAX_HOLD + 1);

  logic              neg_s;
  logic              chan_ok_s;
  logic [ADC_DW-1:0] neg_data_s;
  logic              held_sel_s;
  logic              frame_s;
  logic [HOLD_CNT_W-1:0] hold_next_s;

  logic              v1_r;
  logic [CHAN_W-1:0] chan1_r;
  logic [ADC_DW-1:0] data1_r;
  logic              chop1_r;
  logic              hold1_r;
  logic              en1_r;
  logic              prev_chop0_r;
  logic [HOLD_CNT_W-1:0] hold_cnt_r;
  logic [ADC_DW-1:0] last_good_r [N_CHAN];

  // Stage-1 decode: negate when enabled and the captured phase is the inverted level
  always_comb begin
    neg_s       = chop_en && (chop_dly_i != CHOP_DEFAULT);
    chan_ok_s   = ({1'b0, s_chan} < N_CHAN_L);
    held_sel_s  = en1_r && hold1_r;
    frame_s     = v1_r && (chan1_r == {CHAN_W{1'b0}});
    hold_next_s = hold_cnt_inc(hold_cnt_r);
  end

  sat_negate #(.W(ADC_DW)) u_sat_negate (
    .neg  (neg_s),
    .din  (s_data),
    .dout (neg_data_s)
  );

  // Stage 1: capture the sample with its own phase/hold/enable; illegal channels are dropped here
  always_ff @(posedge adc_data_clk) begin
    if (!reset_n) begin
      v1_r       <= 1'b0;
      chan1_r    <= {CHAN_W{1'b0}};
      data1_r    <= {ADC_DW{1'b0}};
      chop1_r    <= CHOP_DEFAULT;
      hold1_r    <= 1'b0;
      en1_r      <= 1'b0;
      err_chan_o <= 1'b0;
    end else begin
      v1_r <= s_valid && chan_ok_s;
      if (s_valid) begin
        chan1_r <= s_chan;
        data1_r <= neg_data_s;
        chop1_r <= chop_dly_i;
        hold1_r <= data_hold_i;
        en1_r   <= chop_en;
      end
      if (s_valid && !chan_ok_s) begin
        err_chan_o <= 1'b1;
      end
    end
  end

  // Stage 2: registered outputs, last-good substitution and chop period detection on chan 0
  always_ff @(posedge adc_data_clk) begin
    if (!reset_n) begin
      m_valid      <= 1'b0;
      m_chan       <= {CHAN_W{1'b0}};
      m_data       <= {ADC_DW{1'b0}};
      m_held       <= 1'b0;
      period_stb_o <= 1'b0;
      prev_chop0_r <= CHOP_DEFAULT;
      for (int i = 0; i < N_CHAN; i++) begin
        last_good_r[i] <= {ADC_DW{1'b0}};
      end
    end else begin
      m_valid      <= v1_r;
      m_held       <= 1'b0;
      period_stb_o <= 1'b0;
      if (v1_r) begin
        m_chan <= chan1_r;
        if (held_sel_s) begin
          m_data <= last_good_r[chan1_r[IDX_W-1:0]];
          m_held <= 1'b1;
        end else begin
          m_data <= data1_r;
          last_good_r[chan1_r[IDX_W-1:0]] <= data1_r;
        end
      end
      if (frame_s) begin
        prev_chop0_r <= chop1_r;
        period_stb_o <= en1_r && (chop1_r == CHOP_DEFAULT) && (prev_chop0_r != CHOP_DEFAULT);
      end
    end
  end

  // Hold-window length in chan-0 frames; the error flag is sticky until reset
  always_ff @(posedge adc_data_clk) begin
    if (!reset_n) begin
      hold_cnt_r <= {HOLD_CNT_W{1'b0}};
      err_hold_o <= 1'b0;
    end else if (!chop_en) begin
      hold_cnt_r <= {HOLD_CNT_W{1'b0}};
    end else if (frame_s) begin
      if (hold1_r) begin
        hold_cnt_r <= hold_next_s;
        if (hold_next_s >= HOLD_TRIP) begin
          err_hold_o <= 1'b1;
        end
      end else begin
        hold_cnt_r <= {HOLD_CNT_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_chop_demod.sv
// Directed self-checking bench for chop_demod: bypass, saturating negate, hold substitution,
// period strobe, sticky errors and mid-stream reset.
module tb_chop_demod;

  logic        adc_data_clk = 1'b0;
  logic        reset_n;
  logic        chop_en;
  logic        chop_dly_i;
  logic        data_hold_i;
  logic        s_valid;
  logic [5:0]  s_chan;
  logic [17:0] s_data;
  logic        m_valid;
  logic [5:0]  m_chan;
  logic [17:0] m_data;
  logic        m_held;
  logic        period_stb_o;
  logic        err_chan_o;
  logic        err_hold_o;

  int checks = 0;
  int errors = 0;
  logic early;
  int out_idx, pulses, pulse_idx0, pulse_idx1, pulse_bad_chan;

  always #5 adc_data_clk = ~adc_data_clk;

  chop_demod dut (
    .adc_data_clk (adc_data_clk),
    .reset_n      (reset_n),
    .chop_en      (chop_en),
    .chop_dly_i   (chop_dly_i),
    .data_hold_i  (data_hold_i),
    .s_valid      (s_valid),
    .s_chan       (s_chan),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_chan       (m_chan),
    .m_data       (m_data),
    .m_held       (m_held),
    .period_stb_o (period_stb_o),
    .err_chan_o   (err_chan_o),
    .err_hold_o   (err_hold_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample right after an edge; return with outputs settled two edges later.
  task automatic send(input logic [5:0] ch, input logic [17:0] d, input logic chop,
                      input logic hold, output logic mv_early);
    s_valid = 1'b1; s_chan = ch; s_data = d; chop_dly_i = chop; data_hold_i = hold;
    @(posedge adc_data_clk); #1;
    s_valid = 1'b0;
    mv_early = m_valid;
    @(posedge adc_data_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; chop_en = 1'b0; chop_dly_i = 1'b0; data_hold_i = 1'b0;
    s_valid = 1'b0; s_chan = 6'd0; s_data = 18'd0;
    repeat (3) @(posedge adc_data_clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_held", 32'(m_held), 32'd0);
    chk("rst_period", 32'(period_stb_o), 32'd0);
    chk("rst_err_chan", 32'(err_chan_o), 32'd0);
    chk("rst_err_hold", 32'(err_hold_o), 32'd0);
    reset_n = 1'b1;
    @(posedge adc_data_clk); #1;

    // 1: bypass ignores chop and hold
    chop_en = 1'b0;
    send(6'd3, 18'd1000, 1'b1, 1'b1, early);
    chk("byp_latency_early", 32'(early), 32'd0);
    chk("byp_m_valid", 32'(m_valid), 32'd1);
    chk("byp_m_chan", 32'(m_chan), 32'd3);
    chk("byp_m_data", 32'(m_data), 32'd1000);
    chk("byp_m_held", 32'(m_held), 32'd0);
    chk("byp_period", 32'(period_stb_o), 32'd0);
    @(posedge adc_data_clk); #1;
    chk("byp_single_valid", 32'(m_valid), 32'd0);

    // 2: negation and saturation
    chop_en = 1'b1;
    send(6'd1, 18'd1000, 1'b1, 1'b0, early);
    chk("neg_1000", 32'(m_data), 32'h3FC18);
    send(6'd1, 18'h20000, 1'b1, 1'b0, early);
    chk("neg_sat_min", 32'(m_data), 32'h1FFFF);
    send(6'd1, 18'h1FFFF, 1'b1, 1'b0, early);
    chk("neg_max", 32'(m_data), 32'h20001);
    send(6'd1, 18'h3FFFB, 1'b0, 1'b0, early);
    chk("noneg_minus5", 32'(m_data), 32'h3FFFB);

    // 3: hold substitution with last_good
    send(6'd5, 18'd200, 1'b0, 1'b0, early);
    chk("h_unheld_data", 32'(m_data), 32'd200);
    chk("h_unheld_flag", 32'(m_held), 32'd0);
    send(6'd5, 18'd999, 1'b0, 1'b1, early);
    chk("h_held_data", 32'(m_data), 32'd200);
    chk("h_held_flag", 32'(m_held), 32'd1);
    send(6'd5, 18'd555, 1'b1, 1'b1, early);
    chk("h_not_written", 32'(m_data), 32'd200);
    send(6'd5, 18'd7, 1'b1, 1'b0, early);
    chk("h_update_neg", 32'(m_data), 32'h3FFF9);
    send(6'd5, 18'd1, 1'b0, 1'b1, early);
    chk("h_held_new", 32'(m_data), 32'h3FFF9);

    // 4: streaming chop periods; frame phases 1,1,0,0,1,1,0 -> starts at frames 2 and 6
    out_idx = 0; pulses = 0; pulse_idx0 = -1; pulse_idx1 = -1; pulse_bad_chan = 0;
    data_hold_i = 1'b0;
    for (int i = 0; i < 7 * 32 + 2; i++) begin
      if (i < 7 * 32) begin
        s_valid = 1'b1;
        s_chan = 6'(i % 32);
        s_data = 18'(i);
        chop_dly_i = ((i / 32) == 2 || (i / 32) == 3 || (i / 32) == 6) ? 1'b0 : 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      @(posedge adc_data_clk); #1;
      if (m_valid) begin
        if (period_stb_o) begin
          if (pulses == 0) pulse_idx0 = out_idx;
          else pulse_idx1 = out_idx;
          if (m_chan != 6'd0) pulse_bad_chan++;
          pulses++;
        end
        out_idx++;
      end
    end
    s_valid = 1'b0;
    chk("per_out_count", 32'(out_idx), 32'd224);
    chk("per_pulses", 32'(pulses), 32'd2);
    chk("per_first_idx", 32'(pulse_idx0), 32'd64);
    chk("per_second_idx", 32'(pulse_idx1), 32'd192);
    chk("per_on_chan0", 32'(pulse_bad_chan), 32'd0);

    // 5: hold window overrun and illegal channel
    for (int f = 0; f < 8; f++) begin
      send(6'd0, 18'd9, 1'b0, 1'b1, early);
    end
    chk("hold8_no_err", 32'(err_hold_o), 32'd0);
    send(6'd0, 18'd9, 1'b0, 1'b1, early);
    chk("hold9_err", 32'(err_hold_o), 32'd1);
    chk("hold9_still_held", 32'(m_held), 32'd1);
    send(6'd40, 18'd3, 1'b0, 1'b0, early);
    chk("badch_dropped", 32'(m_valid | early), 32'd0);
    chk("badch_err", 32'(err_chan_o), 32'd1);
    chop_en = 1'b0;
    send(6'd0, 18'd4, 1'b1, 1'b1, early);
    chk("en0_no_hold", 32'(m_held), 32'd0);
    chk("en0_sticky_hold", 32'(err_hold_o), 32'd1);

    // 6: reset with samples in flight
    chop_en = 1'b1;
    s_valid = 1'b1; s_chan = 6'd3; s_data = 18'd77; chop_dly_i = 1'b0; data_hold_i = 1'b0;
    @(posedge adc_data_clk); #1;
    s_data = 18'd88; reset_n = 1'b0;
    @(posedge adc_data_clk); #1;
    s_valid = 1'b0;
    chk("rst_flight_valid", 32'(m_valid), 32'd0);
    @(posedge adc_data_clk); #1;
    reset_n = 1'b1;
    chk("rst2_data", 32'(m_data), 32'd0);
    chk("rst2_chan", 32'(m_chan), 32'd0);
    chk("rst2_errs", 32'({err_chan_o, err_hold_o, period_stb_o, m_held}), 32'd0);
    @(posedge adc_data_clk); #1;
    chk("rst2_no_late_valid", 32'(m_valid), 32'd0);
    send(6'd3, 18'd12, 1'b0, 1'b1, early);
    chk("lg3_cleared", 32'(m_data), 32'd0);
    chk("lg3_held", 32'(m_held), 32'd1);
    send(6'd5, 18'd12, 1'b0, 1'b1, early);
    chk("lg5_cleared", 32'(m_data), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
